// File: rtl/keycode_input_mapper.sv
// Maps five HID keycode slots to frame-synchronous move/shoot/pause/start commands.
// Latency: a frame_tick at cycle T updates outputs at the end of T+1 (snapshot, then evaluate).
// No backpressure: accepts one frame_tick per cycle; shoot_valid/start_pulse are one-cycle pulses.
module keycode_input_mapper #(
    parameter int unsigned FIRE_COOLDOWN = 20
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    input  logic [7:0] keycode4,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       shoot_valid,
    output logic [1:0] shoot_dir,
    output logic       paused,
    output logic       start_pulse
);
    localparam int K_W  = 0;
    localparam int K_A  = 1;
    localparam int K_S  = 2;
    localparam int K_D  = 3;
    localparam int K_UP = 4;
    localparam int K_DN = 5;
    localparam int K_LT = 6;
    localparam int K_RT = 7;
    localparam int K_P  = 8;
    localparam int K_EN = 9;

    localparam logic [7:0] CD_RELOAD = 8'(FIRE_COOLDOWN - 1);

    typedef enum logic {READY, COOLDOWN} fire_state_t;

    logic [4:0][7:0] slots;
    logic [9:0]      decoded;
    logic            rollover;

    assign slots = {keycode4, keycode3, keycode2, keycode1, keycode0};

    always_comb begin
        decoded  = '0;
        rollover = 1'b0;
        for (int i = 0; i < 5; i++) begin
            case (slots[i])
                8'h1A:   decoded[K_W]  = 1'b1;
                8'h04:   decoded[K_A]  = 1'b1;
                8'h16:   decoded[K_S]  = 1'b1;
                8'h07:   decoded[K_D]  = 1'b1;
                8'h52:   decoded[K_UP] = 1'b1;
                8'h51:   decoded[K_DN] = 1'b1;
                8'h50:   decoded[K_LT] = 1'b1;
                8'h4F:   decoded[K_RT] = 1'b1;
                8'h13:   decoded[K_P]  = 1'b1;
                8'h28:   decoded[K_EN] = 1'b1;
                8'h01:   rollover      = 1'b1;
                default: ;
            endcase
        end
    end

    // Stage 1: per-frame snapshot; a rollover frame keeps the old held set but still evaluates.
    logic [9:0] held_q;
    logic [9:4] prev_q;
    logic       eval_vld;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            held_q   <= '0;
            prev_q   <= '0;
            eval_vld <= 1'b0;
        end else begin
            eval_vld <= frame_tick;
            if (frame_tick) begin
                prev_q <= held_q[9:4];
                if (!rollover) begin
                    held_q <= decoded;
                end
            end
        end
    end

    logic [3:0] arrows_held;
    logic [3:0] arrows_new;
    logic       p_press;
    logic       en_press;
    logic       paused_nxt;

    assign arrows_held = held_q[K_RT:K_UP];
    assign arrows_new  = held_q[K_RT:K_UP] & ~prev_q[K_RT:K_UP];
    assign p_press     = held_q[K_P] & ~prev_q[K_P];
    assign en_press    = held_q[K_EN] & ~prev_q[K_EN];
    assign paused_nxt  = paused ^ p_press;

    function automatic logic [1:0] pri(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    logic [1:0] last_dir;
    logic [1:0] sel_dir;

    always_comb begin
        sel_dir = last_dir;
        if (|arrows_new) begin
            sel_dir = pri(arrows_new);
        end else if (arrows_held[last_dir]) begin
            sel_dir = last_dir;
        end else if (|arrows_held) begin
            sel_dir = pri(arrows_held);
        end
    end

    // Fire FSM; the new pause state gates it, so a P press wins over a same-frame arrow press.
    fire_state_t state_q, state_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic        fire;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        fire      = 1'b0;
        if (eval_vld && !paused_nxt) begin
            case (state_q)
                READY: begin
                    if (|arrows_held) begin
                        fire      = 1'b1;
                        cnt_nxt   = CD_RELOAD;
                        state_nxt = (CD_RELOAD == 8'd0) ? READY : COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    cnt_nxt   = cnt_q - 8'd1;
                    state_nxt = (cnt_q == 8'd1) ? READY : COOLDOWN;
                end
                default: state_nxt = READY;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= READY;
            cnt_q       <= '0;
            last_dir    <= 2'd0;
            paused      <= 1'b0;
            move_up     <= 1'b0;
            move_down   <= 1'b0;
            move_left   <= 1'b0;
            move_right  <= 1'b0;
            shoot_valid <= 1'b0;
            shoot_dir   <= 2'd0;
            start_pulse <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            shoot_valid <= fire;
            start_pulse <= eval_vld & en_press;
            if (eval_vld) begin
                paused     <= paused_nxt;
                last_dir   <= sel_dir;
                move_up    <= ~paused_nxt & held_q[K_W] & ~held_q[K_S];
                move_down  <= ~paused_nxt & held_q[K_S] & ~held_q[K_W];
                move_left  <= ~paused_nxt & held_q[K_A] & ~held_q[K_D];
                move_right <= ~paused_nxt & held_q[K_D] & ~held_q[K_A];
            end
            if (fire) begin
                shoot_dir <= sel_dir;
            end
        end
    end

endmodule

// File: doc/keycode_input_mapper.md
# keycode_input_mapper

Converts the five raw USB HID keycode slots exported by the NIOS/USB SoC into per-frame game commands: movement (WASD), directional shooting (arrow keys) with a fire-rate cooldown, a pause toggle and a start pulse. It sits directly downstream of the SoC keycode exports and upstream of the player/projectile logic. All decisions are sampled once per video frame, so gameplay is frame-synchronous.

## Interface

**Parameters**
- `FIRE_COOLDOWN`, default 20: number of frames between shots; legal range 1..255, where 1 allows a shot every frame.

**Ports** (name, direction, width, meaning)
- `clk_clk` in 1: system clock, the same clock as the SoC.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame (vsync). Every cycle it is high counts as one tick.
- `keycode0` .. `keycode4` in 8 each: HID keycode slots. 0x00 means empty.
- `move_up`, `move_down`, `move_left`, `move_right` out 1 each: held movement levels.
- `shoot_valid` out 1: one-cycle fire pulse.
- `shoot_dir` out 2: fire direction, valid with `shoot_valid`. Encoding: 00 up, 01 down, 10 left, 11 right.
- `paused` out 1: pause state level.
- `start_pulse` out 1: one-cycle pulse on Enter press.

## Operation

**Key codes**
- W=0x1A, A=0x04, S=0x16, D=0x07.
- Up=0x52, Down=0x51, Left=0x50, Right=0x4F.
- P=0x13, Enter=0x28.
- Any other code is ignored.

**Snapshot (stage 1)**
- On a cycle with `frame_tick`=1, decode all five slots into a held vector `held[9:0]`. A key is held if its code appears in any slot.
- If any slot equals 0x01 (ErrorRollOver), discard the sample: `held` keeps its previous value and the frame is still evaluated.
- `prev[9:0]` holds the `held` value from the previous frame. `pressed = held & ~prev` (rising edge).

**Evaluate (stage 2, the cycle after stage 1)**
- Pause: `paused` toggles when `pressed[P]` is set.
- Start: `start_pulse` is 1 for one cycle when `pressed[Enter]` is set. This happens regardless of `paused`.
- Movement when not paused:
  - `move_up = W & ~S`, `move_down = S & ~W`, `move_left = A & ~D`, `move_right = D & ~A`.
  - Opposite keys held together cancel.
- Movement when paused: all `move_*` are 0.
- Shoot direction selection:
  - If any arrow is newly pressed this frame, select it. If several are newly pressed, priority is Up > Down > Left > Right.
  - Otherwise, if the last selected direction is still held, keep it.
  - Otherwise, select by the same fixed priority among held arrows.
- Fire FSM, states READY (`cnt`=0) and COOLDOWN (`cnt`≠0). `cnt` is 8 bits and is evaluated on ticks only:
  - If paused: no change, `cnt` is frozen, no fire.
  - Else if `cnt`≠0: `cnt` ← `cnt`-1, no fire.
  - Else if any arrow is held: `shoot_valid` pulses, `shoot_dir` takes the selected direction, `cnt` ← `FIRE_COOLDOWN`-1.
  - Else: remain in READY.
- Consequence: if fire occurs at tick N and an arrow stays held, the next fire is at tick N+`FIRE_COOLDOWN`.
- A P press and an arrow press in the same frame: the pause takes effect first, so no fire occurs in that frame.

## Timing

- `frame_tick` sampled high at cycle T: `held`/`pressed` are registered at the end of T, and the outputs update at the end of T+1. Latency is 2 edges.
- `move_*`, `paused` and `shoot_dir` hold their values between ticks.
- `shoot_valid` and `start_pulse` are high for exactly one cycle (T+1 → T+2).
- Keycode changes between ticks are invisible. Only tick-cycle values matter.
- Reset, asserted asynchronously at any time including mid-cooldown:
  - All outputs are 0 and `shoot_dir`=00.
  - `cnt`=0, `held`=`prev`=0, last direction = up, `paused`=0.
- First tick after reset release: keys already held count as `pressed`.
- Back-to-back ticks on consecutive cycles are each fully evaluated. The pipeline accepts one tick per cycle.

## Test plan

- Reset, then W in slot 3, then a tick → `move_up`=1 two cycles later. Add S in slot 0 → at the next tick `move_up`=`move_down`=0.
- `FIRE_COOLDOWN`=4, Up held for 10 ticks → `shoot_valid` on ticks 1, 5 and 9, with `shoot_dir`=00.
- Left held, then Right added at tick 3 → tick 3 fires with `shoot_dir`=11. With Left still held and Right released, the next fire uses 10.
- P in a slot for 3 ticks, released, then pressed again → `paused` goes 1 at the first tick and 0 at the re-press. While paused with D held, `move_right`=0, no fire, and `cnt` is frozen.
- Slot 2=0x01 with W present → `move_up` keeps its prior value. Enter appearing at a tick → `start_pulse` for exactly 1 cycle, also while paused.
- `reset_reset_n` pulled low mid-cooldown (`cnt`=3) → `cnt`=0 and all outputs 0. After release, with an arrow held, a fire occurs at the first tick.
